i2c_tx_datapath: RTL and testbench
==================================

# i2c_tx_datapath

Transmit datapath and bus-line driver for the double-buffered I2C master; sits directly downstream of `txcontroller` and executes its strobes. Holds the two transmit buffers and the address load path, maintains `TXCount`/`BurstCnt`, and turns each start/write/ack/stop command into a timed SCL/SDA slot. Reports completion and acknowledge status back to the controller.

## Interface
- `DATA_W`, 8: transmit byte width.
- `ADDR_W`, 7: slave address width; `DATA_W` = `ADDR_W`+1.
- `CLK_DIV`, 4: clk cycles per SCL quarter-period; minimum 2.

Ports:
- `clk`  in  1  system clock; everything on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `TXData`  in  DATA_W  host byte for buffer loads.
- `TXAddr`  in  ADDR_W  slave address.
- `LoadTXBuf0`, `LoadTXBuf1`, `ShiftTXBuf0`, `ShiftTXBuf1`, `PassTXBuf`, `LoadAddr`  in  1 each  buffer strobes.
- `SendStartSig`, `SendWriteSig`, `WaitAck`, `SendStopSig`  in  1 each  slot commands.
- `ResetTXCount`, `IncTXCount`, `ResetBurstCnt`, `IncBurstCnt`  in  1 each  counter strobes.
- `SDAIn`  in  1  sampled SDA line.
- `TXCount`, `BurstCnt`  out  6 each  bit and byte counters.
- `SCL`  out  1  clock line.
- `SDAOut`  out  1  0 = pull low, 1 = release (open drain).
- `Busy`  out  1  slot in progress.
- `SlotDone`  out  1  one-cycle pulse on the last cycle of each slot.
- `Ackrecvd`  out  1  one-cycle pulse with `SlotDone` of an ack slot when SDA was sampled low.

## Operation
- Reset values: buffers 0, counters 0, `SCL`=1, `SDAOut`=1, `Busy`=0, `SlotDone`=0, `Ackrecvd`=0, state IDLE.
- Buf0 is the shift-out register. Per-cycle priority: `LoadAddr` ({TXAddr,1'b0}) > `PassTXBuf` (buf0 <= buf1) > `LoadTXBuf0` > `ShiftTXBuf0` (left shift, 0 in).
- Buf1 priority: `LoadTXBuf1` > `ShiftTXBuf1`. `PassTXBuf` leaves buf1 unchanged.
- Counters: reset beats increment; increment wraps 63 -> 0. Updates are independent of `Busy`.
- Sequencer states IDLE, START, WRITE, ACK, STOP. A command is accepted only in IDLE.
  - If several commands are high, priority is Start > Stop > Write > Ack; the others are dropped.
  - Commands seen while `Busy`=1 are ignored; there is no queuing.
- A slot has four quarters Q0..Q3.
  - START: SCL 1,1,1,0; SDA 1,0,0,0.
  - STOP: SCL 0,1,1,1; SDA 0,0,1,1.
  - WRITE: SCL 0,0,1,1; SDA holds the bit for the whole slot.
  - ACK: SCL 0,0,1,1; SDA released.
- The WRITE bit is buf0[MSB], latched in the acceptance cycle. A `ShiftTXBuf0` in that same cycle does not affect the transmitted bit.
- ACK samples `SDAIn` on the first cycle of Q2. `Ackrecvd` = ~sample, asserted with `SlotDone`.
- Between slots, IDLE holds the last SCL/SDA of the previous slot. After a STOP, or after reset, that is 1/1.

## Timing
- Acceptance cycle T: `Busy`=1 from T+1.
- The slot occupies T+1 .. T+4·CLK_DIV. `SlotDone` is high in cycle T+4·CLK_DIV; `Busy` is 0 from T+4·CLK_DIV+1.
- The earliest back-to-back command is accepted in the cycle `Busy` returns to 0. No idle quarter is inserted.
- Quarter boundaries fall every CLK_DIV cycles. Line outputs are registered and change on the first cycle of each quarter.
- Reset asserted mid-slot: immediate return to reset values, the slot is abandoned, and no `SlotDone` is issued.

## Structure
- Package `i2c_tx_pkg` holds:
  - the sequencer state enum;
  - the quarter index type;
  - the SCL/SDA per-quarter pattern constants for START/STOP/WRITE/ACK;
  - the counter width constant (6).
- Sub-module `i2c_bit_sequencer` contains the quarter divider, state machine, line registers, ack sampling and `Busy`/`SlotDone`/`Ackrecvd`.
- Buffers and counters stay in the top module.

## Test plan
- Reset: assert `rst_n`=0 mid-WRITE -> `SCL`=1, `SDAOut`=1, counters 0, `Busy`=0 immediately; no `SlotDone`.
- Buffers: `LoadTXBuf1` with TXData=8'hA5, then `PassTXBuf`, then `ShiftTXBuf0` x3 -> buf0=8'h28. `LoadAddr` with TXAddr=7'h3C -> buf0=8'h78.
- Write slot, CLK_DIV=4, buf0=8'h80, `SendWriteSig` at T -> `SCL` low T+1..T+8, high T+9..T+16; `SDAOut`=1 throughout; `SlotDone` at T+16.
- Start then stop -> SDA falls while SCL=1 in Q1 of START; SDA rises while SCL=1 in Q2 of STOP; lines end at 1/1.
- Ack: `SDAIn`=0 at Q2 -> `Ackrecvd` pulse coincides with `SlotDone`. `SDAIn`=1 -> no pulse.
- Counters and arbitration:
  - `IncTXCount` 64 times -> wraps to 0.
  - `ResetTXCount` and `IncTXCount` together -> 0.
  - `SendStartSig` and `SendWriteSig` together -> START only.
  - `SendWriteSig` while `Busy` -> ignored.

Source files
------------

// File: rtl/i2c_tx_datapath_pkg.sv
// Shared types and constants for the I2C transmit datapath: sequencer states,
// quarter index, per-quarter SCL/SDA patterns and the counter width.
package i2c_tx_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_ACK,
        ST_STOP
    } seq_state_t;

    typedef logic [1:0] quarter_t;

    localparam quarter_t Q_FIRST  = 2'd0;
    localparam quarter_t Q_SAMPLE = 2'd2;
    localparam quarter_t Q_LAST   = 2'd3;

    // Bit q of each pattern is the line level during quarter Qq.
    localparam logic [3:0] START_SCL = 4'b0111;
    localparam logic [3:0] START_SDA = 4'b0001;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] STOP_SDA  = 4'b1100;
    localparam logic [3:0] WRITE_SCL = 4'b1100;
    localparam logic [3:0] ACK_SCL   = 4'b1100;
    localparam logic [3:0] ACK_SDA   = 4'b1111;

    // Line levels {scl, sda} for a slot type in a given quarter; a WRITE
    // slot drives its data bit on SDA for all four quarters.
    function automatic logic [1:0] slot_lines(seq_state_t s, quarter_t q, logic data_bit);
        logic [1:0] lines;
        lines = 2'b11;
        case (s)
            ST_START: lines = {START_SCL[q], START_SDA[q]};
            ST_STOP:  lines = {STOP_SCL[q],  STOP_SDA[q]};
            ST_WRITE: lines = {WRITE_SCL[q], data_bit};
            ST_ACK:   lines = {ACK_SCL[q],   ACK_SDA[q]};
            default:  lines = 2'b11;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/i2c_tx_datapath_if.sv
// Strobe/status bundle between the transmit controller and the datapath,
// plus the SCL/SDA bus lines.
interface i2c_tx_datapath_if
    import i2c_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic [DATA_W-1:0] TXData;
    logic [ADDR_W-1:0] TXAddr;
    logic              LoadTXBuf0;
    logic              LoadTXBuf1;
    logic              ShiftTXBuf0;
    logic              ShiftTXBuf1;
    logic              PassTXBuf;
    logic              LoadAddr;
    logic              SendStartSig;
    logic              SendWriteSig;
    logic              WaitAck;
    logic              SendStopSig;
    logic              ResetTXCount;
    logic              IncTXCount;
    logic              ResetBurstCnt;
    logic              IncBurstCnt;
    logic              SDAIn;
    logic [CNT_W-1:0]  TXCount;
    logic [CNT_W-1:0]  BurstCnt;
    logic              SCL;
    logic              SDAOut;
    logic              Busy;
    logic              SlotDone;
    logic              Ackrecvd;

    // Controller side: issues strobes, observes status and lines.
    modport master (
        output TXData, TXAddr,
        output LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf, LoadAddr,
        output SendStartSig, SendWriteSig, WaitAck, SendStopSig,
        output ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt,
        output SDAIn,
        input  TXCount, BurstCnt, SCL, SDAOut, Busy, SlotDone, Ackrecvd
    );

    // Datapath side: executes strobes, drives status and lines.
    modport slave (
        input  TXData, TXAddr,
        input  LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf, LoadAddr,
        input  SendStartSig, SendWriteSig, WaitAck, SendStopSig,
        input  ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt,
        input  SDAIn,
        output TXCount, BurstCnt, SCL, SDAOut, Busy, SlotDone, Ackrecvd
    );

endinterface

// File: rtl/i2c_tx_datapath_seq.sv
// Bit-slot sequencer: turns one accepted command into a four-quarter SCL/SDA
// slot, samples the acknowledge bit and reports Busy/SlotDone/Ackrecvd.
module i2c_bit_sequencer
    import i2c_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_cmd,
    input  logic stop_cmd,
    input  logic write_cmd,
    input  logic ack_cmd,
    input  logic tx_bit,
    input  logic sda_in,
    output logic scl,
    output logic sda_out,
    output logic busy,
    output logic slot_done,
    output logic ack_recvd
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    seq_state_t       state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    quarter_t         quarter_reg, quarter_next;
    logic             scl_reg, scl_next;
    logic             sda_reg, sda_next;
    logic             bit_reg, bit_next;
    logic             ack_sample_reg, ack_sample_next;
    logic             quarter_end;
    logic             slot_end;

    assign quarter_end = (div_reg == DIV_LAST);
    assign slot_end    = (state_reg != ST_IDLE) && quarter_end && (quarter_reg == Q_LAST);

    // State, divider and line registers; reset leaves the bus released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            div_reg        <= '0;
            quarter_reg    <= Q_FIRST;
            scl_reg        <= 1'b1;
            sda_reg        <= 1'b1;
            bit_reg        <= 1'b0;
            ack_sample_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            quarter_reg    <= quarter_next;
            scl_reg        <= scl_next;
            sda_reg        <= sda_next;
            bit_reg        <= bit_next;
            ack_sample_reg <= ack_sample_next;
        end
    end

    // Command acceptance in IDLE, quarter stepping and next line levels.
    always_comb begin
        state_next      = state_reg;
        div_next        = div_reg;
        quarter_next    = quarter_reg;
        scl_next        = scl_reg;
        sda_next        = sda_reg;
        bit_next        = bit_reg;
        ack_sample_next = ack_sample_reg;

        if (state_reg == ST_IDLE) begin
            // Start > Stop > Write > Ack; lower-priority commands are dropped.
            if (start_cmd)      state_next = ST_START;
            else if (stop_cmd)  state_next = ST_STOP;
            else if (write_cmd) state_next = ST_WRITE;
            else if (ack_cmd)   state_next = ST_ACK;

            if (state_next != ST_IDLE) begin
                div_next        = '0;
                quarter_next    = Q_FIRST;
                bit_next        = tx_bit;
                ack_sample_next = 1'b1;
                {scl_next, sda_next} = slot_lines(state_next, Q_FIRST, tx_bit);
            end
        end else begin
            if (state_reg == ST_ACK && quarter_reg == Q_SAMPLE && div_reg == '0) begin
                ack_sample_next = sda_in;
            end

            if (quarter_end) begin
                div_next = '0;
                if (quarter_reg == Q_LAST) begin
                    // Lines keep the last quarter's levels while idle.
                    state_next = ST_IDLE;
                end else begin
                    quarter_next = quarter_reg + 2'd1;
                    {scl_next, sda_next} = slot_lines(state_reg, quarter_reg + 2'd1, bit_reg);
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    assign scl       = scl_reg;
    assign sda_out   = sda_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign slot_done = slot_end;
    assign ack_recvd = slot_end && (state_reg == ST_ACK) && !ack_sample_reg;

endmodule

// File: rtl/i2c_tx_datapath.sv
// Transmit datapath: double transmit buffer with address load, bit/byte
// counters, and the bit-slot sequencer that drives SCL/SDA.
module i2c_tx_datapath
    import i2c_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_tx_datapath_if.slave   ctrl
);

    logic [DATA_W-1:0]        buf0_reg, buf0_next;
    logic [DATA_W-1:0]        buf1_reg, buf1_next;
    logic [ADDR_W:0]          addr_word;
    logic [1:0]               cnt_clear;
    logic [1:0]               cnt_step;
    logic [1:0][CNT_W-1:0]    cnt_value;

    // Address byte goes out with a zero R/W bit (write).
    assign addr_word = {ctrl.TXAddr, 1'b0};

    // Buf0 is the shift-out register: address > pass > load > shift.
    always_comb begin
        buf0_next = buf0_reg;
        if (ctrl.LoadAddr)         buf0_next = addr_word;
        else if (ctrl.PassTXBuf)   buf0_next = buf1_reg;
        else if (ctrl.LoadTXBuf0)  buf0_next = ctrl.TXData;
        else if (ctrl.ShiftTXBuf0) buf0_next = {buf0_reg[DATA_W-2:0], 1'b0};
    end

    // Buf1 is the staging buffer; a pass does not disturb it.
    always_comb begin
        buf1_next = buf1_reg;
        if (ctrl.LoadTXBuf1)       buf1_next = ctrl.TXData;
        else if (ctrl.ShiftTXBuf1) buf1_next = {buf1_reg[DATA_W-2:0], 1'b0};
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_reg <= '0;
            buf1_reg <= '0;
        end else begin
            buf0_reg <= buf0_next;
            buf1_reg <= buf1_next;
        end
    end

    // Counter 0 is TXCount (bits), counter 1 is BurstCnt (bytes).
    assign cnt_clear = {ctrl.ResetBurstCnt, ctrl.ResetTXCount};
    assign cnt_step  = {ctrl.IncBurstCnt,   ctrl.IncTXCount};

    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [CNT_W-1:0] count_reg;

        // Clear wins over increment; increment wraps naturally at 2^CNT_W.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              count_reg <= '0;
            else if (cnt_clear[gi])  count_reg <= '0;
            else if (cnt_step[gi])   count_reg <= count_reg + CNT_W'(1);
        end

        assign cnt_value[gi] = count_reg;
    end

    assign ctrl.TXCount  = cnt_value[0];
    assign ctrl.BurstCnt = cnt_value[1];

    i2c_bit_sequencer #(
        .CLK_DIV (CLK_DIV)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_cmd (ctrl.SendStartSig),
        .stop_cmd  (ctrl.SendStopSig),
        .write_cmd (ctrl.SendWriteSig),
        .ack_cmd   (ctrl.WaitAck),
        .tx_bit    (buf0_reg[DATA_W-1]),
        .sda_in    (ctrl.SDAIn),
        .scl       (ctrl.SCL),
        .sda_out   (ctrl.SDAOut),
        .busy      (ctrl.Busy),
        .slot_done (ctrl.SlotDone),
        .ack_recvd (ctrl.Ackrecvd)
    );

endmodule

// File: tb/tb_i2c_tx_datapath.sv
// Scoreboard bench: stimulus pushes expected slots, a negedge monitor pops
// and compares whole SCL/SDA slot waveforms, latency and acknowledge.
module tb_i2c_tx_datapath;

    localparam int D    = 4;
    localparam int SLOT = 4 * D;
    localparam int K_START = 0, K_STOP = 1, K_WRITE = 2, K_ACK = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_tx_datapath_if #(.DATA_W(8), .ADDR_W(7)) bus ();

    i2c_tx_datapath #(.DATA_W(8), .ADDR_W(7), .CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    typedef struct packed {
        logic laddr, pass, load0, shift0, load1, shift1;
        logic start, stop, write, ack;
        logic rtx, itx, rbc, ibc;
    } strb_t;

    typedef struct {
        int kind;
        bit b;
        bit ack;
        int start;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   busy_last = -1;
    int   m_buf0 = 0, m_buf1 = 0, m_tx = 0, m_bc = 0;
    logic       sdain_v = 1'b1;
    logic [7:0] data_v  = '0;
    logic [6:0] addr_v  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit exp_scl(input int k, input int q);
        case (k)
            K_START: return q != 3;
            K_STOP:  return q != 0;
            default: return q >= 2;
        endcase
    endfunction

    function automatic bit exp_sda(input int k, input int q, input bit b);
        case (k)
            K_START: return q == 0;
            K_STOP:  return q >= 2;
            K_WRITE: return b;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_strobes();
        bus.LoadAddr = 0; bus.PassTXBuf = 0; bus.LoadTXBuf0 = 0; bus.ShiftTXBuf0 = 0;
        bus.LoadTXBuf1 = 0; bus.ShiftTXBuf1 = 0;
        bus.SendStartSig = 0; bus.SendStopSig = 0; bus.SendWriteSig = 0; bus.WaitAck = 0;
        bus.ResetTXCount = 0; bus.IncTXCount = 0; bus.ResetBurstCnt = 0; bus.IncBurstCnt = 0;
    endtask

    // Drive one cycle of strobes and advance the reference model.
    task automatic apply(input strb_t s);
        exp_t e;
        bus.LoadAddr = s.laddr; bus.PassTXBuf = s.pass; bus.LoadTXBuf0 = s.load0;
        bus.ShiftTXBuf0 = s.shift0; bus.LoadTXBuf1 = s.load1; bus.ShiftTXBuf1 = s.shift1;
        bus.SendStartSig = s.start; bus.SendStopSig = s.stop;
        bus.SendWriteSig = s.write; bus.WaitAck = s.ack;
        bus.ResetTXCount = s.rtx; bus.IncTXCount = s.itx;
        bus.ResetBurstCnt = s.rbc; bus.IncBurstCnt = s.ibc;
        bus.TXData = data_v; bus.TXAddr = addr_v; bus.SDAIn = sdain_v;

        if (cyc > busy_last && (s.start || s.stop || s.write || s.ack)) begin
            e.kind  = s.start ? K_START : s.stop ? K_STOP : s.write ? K_WRITE : K_ACK;
            e.b     = m_buf0[7];
            e.ack   = (e.kind == K_ACK) && !sdain_v;
            e.start = cyc + 1;
            exp_q.push_back(e);
            busy_last = cyc + SLOT;
        end

        if (s.laddr)       m_buf0 = int'(addr_v) * 2;
        else if (s.pass)   m_buf0 = m_buf1;
        else if (s.load0)  m_buf0 = int'(data_v);
        else if (s.shift0) m_buf0 = (m_buf0 * 2) % 256;

        if (s.load1)       m_buf1 = int'(data_v);
        else if (s.shift1) m_buf1 = (m_buf1 * 2) % 256;

        if (s.rtx)      m_tx = 0;
        else if (s.itx) m_tx = (m_tx + 1) % 64;
        if (s.rbc)      m_bc = 0;
        else if (s.ibc) m_bc = (m_bc + 1) % 64;

        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply('0);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_last) apply('0);
    endtask

    task automatic send_byte();
        strb_t s;
        for (int i = 0; i < 8; i++) begin
            s = '0; s.write = 1'b1; s.shift0 = 1'b1;
            apply(s);
            wait_idle();
        end
    endtask

    task automatic check_counters();
        check("txcount",  64'(bus.TXCount),  64'(m_tx));
        check("burstcnt", 64'(bus.BurstCnt), 64'(m_bc));
    endtask

    // Monitor: capture each slot from Busy rise to SlotDone and score it.
    initial begin : monitor
        bit          in_slot;
        int          s_start, s_len;
        logic [63:0] a_scl, a_sda, e_scl, e_sda;
        bit          idle_scl, idle_sda;
        exp_t        e;
        in_slot = 0; s_start = 0; s_len = 0; idle_scl = 1; idle_sda = 1;
        a_scl = '0; a_sda = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_slot  = 0;
                idle_scl = 1;
                idle_sda = 1;
            end else begin
                if (bus.Busy && !in_slot) begin
                    in_slot = 1; s_start = cyc; s_len = 0; a_scl = '0; a_sda = '0;
                end
                if (in_slot) begin
                    if (s_len < 64) begin
                        a_scl[s_len] = bus.SCL;
                        a_sda[s_len] = bus.SDAOut;
                    end
                    s_len++;
                end else begin
                    check("idle_lines", {62'd0, bus.SCL, bus.SDAOut}, {62'd0, idle_scl, idle_sda});
                end
                if (bus.Ackrecvd && !bus.SlotDone) begin
                    n_cmp++; n_err++;
                    $display("FAIL ackrecvd_alone: actual Ackrecvd=1 SlotDone=0, required pulse only with SlotDone (cycle %0d)", cyc);
                end
                if (bus.SlotDone) begin
                    if (!in_slot || exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_slot: actual SlotDone at cycle %0d, required no slot", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        e_scl = '0; e_sda = '0;
                        for (int i = 0; i < SLOT; i++) begin
                            e_scl[i] = exp_scl(e.kind, i / D);
                            e_sda[i] = exp_sda(e.kind, i / D, e.b);
                        end
                        check("slot_start",  64'(s_start), 64'(e.start));
                        check("slot_length", 64'(s_len),   64'(SLOT));
                        check("slot_scl",    a_scl,        e_scl);
                        check("slot_sda",    a_sda,        e_sda);
                        check("ackrecvd",    64'(bus.Ackrecvd), 64'(e.ack));
                        idle_scl = exp_scl(e.kind, 3);
                        idle_sda = exp_sda(e.kind, 3, e.b);
                    end
                    in_slot = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        strb_t s;
        clear_strobes();
        bus.TXData = '0; bus.TXAddr = '0; bus.SDAIn = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_scl",      64'(bus.SCL),      64'(1));
        check("reset_sda",      64'(bus.SDAOut),   64'(1));
        check("reset_busy",     64'(bus.Busy),     64'(0));
        check("reset_slotdone", 64'(bus.SlotDone), 64'(0));
        check("reset_ackrecvd", 64'(bus.Ackrecvd), 64'(0));
        check_counters();
        rst_n = 1'b1;
        idle_cycles(2);

        // Buffer path: A5 -> pass -> three shifts gives 28, sent MSB first.
        data_v = 8'hA5; s = '0; s.load1 = 1; apply(s);
        s = '0; s.pass = 1; apply(s);
        repeat (3) begin s = '0; s.shift0 = 1; apply(s); end
        send_byte();
        // Address load 3C gives 78 on the wire.
        addr_v = 7'h3C; s = '0; s.laddr = 1; apply(s);
        send_byte();
        // Single write of a 1 bit from buf0 = 80.
        data_v = 8'h80; s = '0; s.load0 = 1; apply(s);
        s = '0; s.write = 1; apply(s);
        wait_idle();

        // Start then stop, then a back-to-back write.
        s = '0; s.start = 1; apply(s); wait_idle();
        s = '0; s.stop  = 1; apply(s); wait_idle();
        s = '0; s.write = 1; apply(s); wait_idle();

        // Acknowledge slots: SDA low acknowledges, SDA high does not.
        sdain_v = 1'b0; s = '0; s.ack = 1; apply(s); wait_idle();
        sdain_v = 1'b1; s = '0; s.ack = 1; apply(s); wait_idle();

        // Arbitration and commands while busy.
        s = '0; s.start = 1; s.write = 1; apply(s);
        idle_cycles(3);
        s = '0; s.write = 1; apply(s);
        wait_idle();
        s = '0; s.stop = 1; s.write = 1; s.ack = 1; apply(s); wait_idle();
        sdain_v = 1'b0; s = '0; s.write = 1; s.ack = 1; apply(s); wait_idle();
        sdain_v = 1'b1;

        // Counters: wrap after 64 increments, clear beats increment.
        repeat (64) begin s = '0; s.itx = 1; apply(s); end
        check_counters();
        repeat (5) begin s = '0; s.itx = 1; s.ibc = 1; apply(s); end
        check_counters();
        s = '0; s.rtx = 1; s.itx = 1; s.ibc = 1; apply(s);
        check_counters();
        s = '0; s.rbc = 1; s.ibc = 1; apply(s);
        check_counters();

        // Randomized mix of every strobe, including commands while busy.
        repeat (400) begin
            s = '0;
            s.laddr  = ($urandom_range(15, 0) == 0);
            s.pass   = ($urandom_range(11, 0) == 0);
            s.load0  = ($urandom_range(7, 0) == 0);
            s.shift0 = ($urandom_range(3, 0) == 0);
            s.load1  = ($urandom_range(7, 0) == 0);
            s.shift1 = ($urandom_range(3, 0) == 0);
            s.start  = ($urandom_range(9, 0) == 0);
            s.stop   = ($urandom_range(9, 0) == 0);
            s.write  = ($urandom_range(4, 0) == 0);
            s.ack    = ($urandom_range(5, 0) == 0);
            s.rtx    = ($urandom_range(15, 0) == 0);
            s.itx    = ($urandom_range(1, 0) == 0);
            s.rbc    = ($urandom_range(15, 0) == 0);
            s.ibc    = ($urandom_range(2, 0) == 0);
            data_v   = 8'($urandom);
            addr_v   = 7'($urandom);
            if (cyc > busy_last) sdain_v = 1'($urandom);
            apply(s);
            check_counters();
        end
        wait_idle();

        // Reset in the middle of a write slot.
        repeat (3) begin s = '0; s.itx = 1; s.ibc = 1; apply(s); end
        data_v = 8'hFF; s = '0; s.load0 = 1; apply(s);
        s = '0; s.write = 1; apply(s);
        idle_cycles(5);
        rst_n = 1'b0;
        #1;
        check("midreset_scl",      64'(bus.SCL),      64'(1));
        check("midreset_sda",      64'(bus.SDAOut),   64'(1));
        check("midreset_busy",     64'(bus.Busy),     64'(0));
        check("midreset_slotdone", 64'(bus.SlotDone), 64'(0));
        m_buf0 = 0; m_buf1 = 0; m_tx = 0; m_bc = 0;
        exp_q.delete();
        busy_last = -1;
        check_counters();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);
        // Buffers are cleared, so this write sends a 0.
        s = '0; s.write = 1; apply(s);
        wait_idle();
        idle_cycles(3);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
